// File: rtl/atomic_pkg.sv
// Shared types for the atomic controller: FSM state encoding, opcodes and cmd field offsets.
// CAS states exist only when ATOMIC_CAS_EN is defined.
package atomic_pkg;

   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CAS = 3'b111;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DECODE     = 3'd1,
      EXECUTE    = 3'd2,
      WRITE_BACK = 3'd3
`ifdef ATOMIC_CAS_EN
      ,
      CAS_CMP    = 3'd4,
      CAS_SWAP   = 3'd5
`endif
   } state_t;

   // cmd is {op[2:0], ra, rb, rd}, MSB first, each register field aw bits wide
   function automatic int cmd_width(input int aw);
      return 3 + 3 * aw;
   endfunction

   function automatic int op_lsb(input int aw);
      return 3 * aw;
   endfunction

   function automatic int ra_lsb(input int aw);
      return 2 * aw;
   endfunction

   function automatic int rb_lsb(input int aw);
      return aw;
   endfunction

   function automatic int rd_lsb(input int aw);
      return 0;
   endfunction

endpackage

// File: rtl/atomic_if.sv
// Command, host register access and external-ALU signals of the atomic controller.
// master = host/ALU side, slave = controller side.
interface atomic_if #(
   parameter int DW   = 32,
   parameter int NREG = 8
);
   localparam int AW = $clog2(NREG);
   localparam int CW = 3 + 3 * AW;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [2:0]    alu_op;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_y;
   logic          alu_z;
   logic          done;
   logic          cas_ok;

   modport master (
      output cmd_valid, cmd, wr_en, wr_addr, wr_data, rd_addr, alu_y, alu_z,
      input  cmd_ready, rd_data, alu_op, alu_a, alu_b, done, cas_ok
   );

   modport slave (
      input  cmd_valid, cmd, wr_en, wr_addr, wr_data, rd_addr, alu_y, alu_z,
      output cmd_ready, rd_data, alu_op, alu_a, alu_b, done, cas_ok
   );

endinterface

// File: rtl/atomic_regfile.sv
// NREG x DW register file, sync reset, NRD async read ports, two write ports (port 1 wins on same address).
// Both write ports land on the same edge so a swap is atomic.
module atomic_regfile #(
   parameter int DW   = 32,
   parameter int NREG = 8,
   parameter int NRD  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NREG)-1:0] raddr  [NRD],
   output logic [DW-1:0]           rdata  [NRD],
   input  logic                    we0,
   input  logic [$clog2(NREG)-1:0] waddr0,
   input  logic [DW-1:0]           wdata0,
   input  logic                    we1,
   input  logic [$clog2(NREG)-1:0] waddr1,
   input  logic [DW-1:0]           wdata1
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (we0) regs[waddr0] <= wdata0;
         if (we1) regs[waddr1] <= wdata1;
      end
   end

   always_comb begin
      for (int r = 0; r < NRD; r++) rdata[r] = regs[raddr[r]];
   end

endmodule

// File: rtl/atomic_controller.sv
// Register-file command controller driving an external ALU; done 3 cycles after cmd transfer, cmd_ready only in IDLE.
// Optional compare-and-swap on op 3'b111 when ATOMIC_CAS_EN is defined.
module atomic_controller
   import atomic_pkg::*;
#(
   parameter int DW   = 32,
   parameter int NREG = 8
) (
   input  logic     clk,
   input  logic     rst,
   atomic_if.slave  bus
);

   localparam int AW = $clog2(NREG);
   localparam int CW = cmd_width(AW);
   localparam int OP_L = op_lsb(AW);
   localparam int RA_L = ra_lsb(AW);
   localparam int RB_L = rb_lsb(AW);
   localparam int RD_L = rd_lsb(AW);

   state_t        state, state_nx;
   logic [CW-1:0] cmd_q;
   logic [DW-1:0] y_q;
   logic          xfer;
   logic [2:0]    op_q;
   logic [AW-1:0] ra_q, rb_q, rd_q;

   // read ports: 0 = R[ra], 1 = R[rb], 2 = R[rd], 3 = host
   logic [AW-1:0] rf_raddr [4];
   logic [DW-1:0] rf_rdata [4];
   logic          we0, we1;
   logic [AW-1:0] waddr0, waddr1;
   logic [DW-1:0] wdata0, wdata1;

   assign op_q = cmd_q[OP_L +: 3];
   assign ra_q = cmd_q[RA_L +: AW];
   assign rb_q = cmd_q[RB_L +: AW];
   assign rd_q = cmd_q[RD_L +: AW];

   assign bus.cmd_ready = (state == IDLE);
   assign xfer          = bus.cmd_valid && bus.cmd_ready;

   assign rf_raddr[0] = ra_q;
   assign rf_raddr[1] = rb_q;
   assign rf_raddr[2] = rd_q;
   assign rf_raddr[3] = bus.rd_addr;
   assign bus.rd_data = rf_rdata[3];

   atomic_regfile #(.DW(DW), .NREG(NREG), .NRD(4)) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr  (rf_raddr),
      .rdata  (rf_rdata),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cmd_q <= '0;
         y_q   <= '0;
      end else begin
         state <= state_nx;
         if (xfer) cmd_q <= bus.cmd;
         if (state == EXECUTE) y_q <= bus.alu_y;
      end
   end

`ifdef ATOMIC_CAS_EN
   logic z_q;

   always_ff @(posedge clk) begin
      if (rst) z_q <= 1'b0;
      else if (state == CAS_CMP) z_q <= bus.alu_z;
   end
`else
   logic unused_cas;
   assign unused_cas = bus.alu_z ^ (^rf_rdata[2]);
   assign bus.cas_ok = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (xfer) state_nx = DECODE;
`ifdef ATOMIC_CAS_EN
         DECODE:     state_nx = (op_q == OP_CAS) ? CAS_CMP : EXECUTE;
         CAS_CMP:    state_nx = CAS_SWAP;
         CAS_SWAP:   state_nx = IDLE;
`else
         DECODE:     state_nx = EXECUTE;
`endif
         EXECUTE:    state_nx = WRITE_BACK;
         WRITE_BACK: state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.alu_op = '0;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.done   = 1'b0;
`ifdef ATOMIC_CAS_EN
      bus.cas_ok = 1'b0;
`endif
      we0    = 1'b0;
      waddr0 = rd_q;
      wdata0 = y_q;
      we1    = 1'b0;
      waddr1 = rd_q;
      wdata1 = rf_rdata[0];
      case (state)
         IDLE: begin
            // a command transferring this cycle takes priority over the host write
            if (bus.wr_en && !xfer) begin
               we0    = 1'b1;
               waddr0 = bus.wr_addr;
               wdata0 = bus.wr_data;
            end
         end
         EXECUTE: begin
            bus.alu_op = op_q;
            bus.alu_a  = rf_rdata[0];
            bus.alu_b  = rf_rdata[1];
         end
         WRITE_BACK: begin
            we0      = 1'b1;
            bus.done = 1'b1;
         end
`ifdef ATOMIC_CAS_EN
         CAS_CMP: begin
            bus.alu_op = OP_SUB;
            bus.alu_a  = rf_rdata[0];
            bus.alu_b  = rf_rdata[1];
         end
         CAS_SWAP: begin
            bus.done   = 1'b1;
            bus.cas_ok = z_q;
            // with ra==rd both ports write the same value back, leaving it unchanged
            if (z_q) begin
               we0    = 1'b1;
               waddr0 = ra_q;
               wdata0 = rf_rdata[2];
               we1    = 1'b1;
               waddr1 = rd_q;
               wdata1 = rf_rdata[0];
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_atomic_controller.sv
// Directed bench for atomic_controller with a small combinational ALU model.
module tb_atomic_controller;

   logic clk;
   logic rst;
   int   vecs;
   int   errs;

   atomic_if #(.DW(32), .NREG(8)) bus ();

   atomic_controller #(.DW(32), .NREG(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 000 add, 001 sub, 010 and, 011 or, 100 xor, 111 a & ~b
   always_comb begin
      case (bus.alu_op)
         3'b000:  bus.alu_y = bus.alu_a + bus.alu_b;
         3'b001:  bus.alu_y = bus.alu_a - bus.alu_b;
         3'b010:  bus.alu_y = bus.alu_a & bus.alu_b;
         3'b011:  bus.alu_y = bus.alu_a | bus.alu_b;
         3'b100:  bus.alu_y = bus.alu_a ^ bus.alu_b;
         3'b111:  bus.alu_y = bus.alu_a & ~bus.alu_b;
         default: bus.alu_y = '0;
      endcase
      bus.alu_z = (bus.alu_y == 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic peek(input logic [2:0] a, output logic [31:0] v);
      bus.rd_addr = a;
      #1;
      v = bus.rd_data;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd = '0;
      bus.wr_en = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      tick();
      tick();
      rst = 1'b0;
      vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", bus.done); end
      vecs++; if (bus.cas_ok !== 1'b0) begin errs++; $display("FAIL rst_cas_ok: got %b want 0", bus.cas_ok); end
      vecs++; if (bus.alu_op !== 3'd0) begin errs++; $display("FAIL rst_alu_op: got %0d want 0", bus.alu_op); end
      vecs++; if (bus.alu_a !== 32'd0) begin errs++; $display("FAIL rst_alu_a: got %0h want 0", bus.alu_a); end
      peek(3'd7, v);
      vecs++; if (v !== 32'd0) begin errs++; $display("FAIL rst_r7: got %0h want 0", v); end
   endtask

   task automatic test_alu_op();
      logic [31:0] v;
      host_write(3'd1, 32'd5);
      host_write(3'd2, 32'd3);
      bus.cmd = {3'b000, 3'd1, 3'd2, 3'd7};
      bus.cmd_valid = 1'b1;
      vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL add_ready_idle: got %b want 1", bus.cmd_ready); end
      tick();
      bus.cmd_valid = 1'b0;
      vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL add_ready_decode: got %b want 0", bus.cmd_ready); end
      vecs++; if (bus.alu_a !== 32'd0) begin errs++; $display("FAIL add_alu_a_decode: got %0h want 0", bus.alu_a); end
      tick();
      vecs++; if (bus.alu_op !== 3'd0) begin errs++; $display("FAIL add_alu_op: got %0d want 0", bus.alu_op); end
      vecs++; if (bus.alu_a !== 32'd5) begin errs++; $display("FAIL add_alu_a: got %0h want 5", bus.alu_a); end
      vecs++; if (bus.alu_b !== 32'd3) begin errs++; $display("FAIL add_alu_b: got %0h want 3", bus.alu_b); end
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL add_done_early: got %b want 0", bus.done); end
      tick();
      vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL add_done: got %b want 1", bus.done); end
      vecs++; if (bus.cas_ok !== 1'b0) begin errs++; $display("FAIL add_cas_ok: got %b want 0", bus.cas_ok); end
      vecs++; if (bus.alu_b !== 32'd0) begin errs++; $display("FAIL add_alu_b_wb: got %0h want 0", bus.alu_b); end
      tick();
      vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL add_ready_back: got %b want 1", bus.cmd_ready); end
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
      peek(3'd7, v);
      vecs++; if (v !== 32'd8) begin errs++; $display("FAIL add_r7: got %0h want 8", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      bus.cmd = {3'b100, 3'd1, 3'd2, 3'd5};
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd = {3'b000, 3'd7, 3'd1, 3'd6};
      vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_dec: got %b want 0", bus.cmd_ready); end
      tick();
      vecs++; if (bus.alu_a !== 32'd5) begin errs++; $display("FAIL b2b_first_a: got %0h want 5", bus.alu_a); end
      vecs++; if (bus.alu_op !== 3'b100) begin errs++; $display("FAIL b2b_first_op: got %0d want 4", bus.alu_op); end
      tick();
      vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL b2b_done1: got %b want 1", bus.done); end
      vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_done: got %b want 0", bus.cmd_ready); end
      tick();
      vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_after: got %b want 1", bus.cmd_ready); end
      peek(3'd5, v);
      vecs++; if (v !== 32'd6) begin errs++; $display("FAIL b2b_r5: got %0h want 6", v); end
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      vecs++; if (bus.alu_a !== 32'd8) begin errs++; $display("FAIL b2b_second_a: got %0h want 8", bus.alu_a); end
      vecs++; if (bus.alu_b !== 32'd5) begin errs++; $display("FAIL b2b_second_b: got %0h want 5", bus.alu_b); end
      tick();
      vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL b2b_done2: got %b want 1", bus.done); end
      tick();
      peek(3'd6, v);
      vecs++; if (v !== 32'd13) begin errs++; $display("FAIL b2b_r6: got %0h want d", v); end
   endtask

   task automatic test_write_gating();
      logic [31:0] v;
      bus.cmd = {3'b011, 3'd1, 3'd2, 3'd4};
      bus.cmd_valid = 1'b1;
      bus.wr_en = 1'b1;
      bus.wr_addr = 3'd3;
      bus.wr_data = 32'hAA;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      bus.wr_en = 1'b0;
      tick();
      peek(3'd3, v);
      vecs++; if (v !== 32'd0) begin errs++; $display("FAIL gate_r3: got %0h want 0", v); end
      peek(3'd4, v);
      vecs++; if (v !== 32'd7) begin errs++; $display("FAIL gate_r4: got %0h want 7", v); end
      host_write(3'd0, 32'h1234);
      peek(3'd0, v);
      vecs++; if (v !== 32'h1234) begin errs++; $display("FAIL gate_r0: got %0h want 1234", v); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      bus.cmd = {3'b000, 3'd1, 3'd2, 3'd3};
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      vecs++; if (bus.alu_a !== 32'd5) begin errs++; $display("FAIL rstmid_exec_a: got %0h want 5", bus.alu_a); end
      rst = 1'b1;
      bus.wr_en = 1'b1;
      bus.wr_addr = 3'd2;
      bus.wr_data = 32'h77;
      tick();
      rst = 1'b0;
      bus.wr_en = 1'b0;
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
      vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", bus.cmd_ready); end
      peek(3'd3, v);
      vecs++; if (v !== 32'd0) begin errs++; $display("FAIL rstmid_r3: got %0h want 0", v); end
      peek(3'd2, v);
      vecs++; if (v !== 32'd0) begin errs++; $display("FAIL rstmid_r2: got %0h want 0", v); end
      tick();
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rstmid_no_pulse: got %b want 0", bus.done); end
   endtask

`ifdef ATOMIC_CAS_EN
   task automatic test_cas(input logic [31:0] r2, input logic [2:0] rd, input logic exp_ok,
                           input logic [31:0] exp_r1, input logic [31:0] exp_r3);
      logic [31:0] v;
      host_write(3'd1, 32'd9);
      host_write(3'd2, r2);
      host_write(3'd3, 32'h55);
      bus.cmd = {3'b111, 3'd1, 3'd2, rd};
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      vecs++; if (bus.alu_op !== 3'b001) begin errs++; $display("FAIL cas_alu_op: got %0d want 1", bus.alu_op); end
      vecs++; if (bus.alu_b !== r2) begin errs++; $display("FAIL cas_alu_b: got %0h want %0h", bus.alu_b, r2); end
      tick();
      vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL cas_done: got %b want 1", bus.done); end
      vecs++; if (bus.cas_ok !== exp_ok) begin errs++; $display("FAIL cas_ok: got %b want %b", bus.cas_ok, exp_ok); end
      tick();
      peek(3'd1, v);
      vecs++; if (v !== exp_r1) begin errs++; $display("FAIL cas_r1: got %0h want %0h", v, exp_r1); end
      peek(3'd3, v);
      vecs++; if (v !== exp_r3) begin errs++; $display("FAIL cas_r3: got %0h want %0h", v, exp_r3); end
   endtask
`else
   task automatic test_op7();
      logic [31:0] v;
      host_write(3'd1, 32'hF0);
      host_write(3'd2, 32'h3C);
      bus.cmd = {3'b111, 3'd1, 3'd2, 3'd4};
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      vecs++; if (bus.alu_op !== 3'b111) begin errs++; $display("FAIL op7_alu_op: got %0d want 7", bus.alu_op); end
      vecs++; if (bus.alu_a !== 32'hF0) begin errs++; $display("FAIL op7_alu_a: got %0h want f0", bus.alu_a); end
      tick();
      vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL op7_done: got %b want 1", bus.done); end
      vecs++; if (bus.cas_ok !== 1'b0) begin errs++; $display("FAIL op7_cas_ok: got %b want 0", bus.cas_ok); end
      tick();
      peek(3'd4, v);
      vecs++; if (v !== 32'hC0) begin errs++; $display("FAIL op7_r4: got %0h want c0", v); end
   endtask
`endif

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_alu_op();
      test_back_to_back();
      test_write_gating();
      test_reset_mid();
`ifdef ATOMIC_CAS_EN
      test_cas(32'd9, 3'd3, 1'b1, 32'h55, 32'd9);
      test_cas(32'd8, 3'd3, 1'b0, 32'd9, 32'h55);
      test_cas(32'd9, 3'd1, 1'b1, 32'd9, 32'h55);
`else
      test_op7();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
